// File: rtl/l2_cache_pkg.sv
// Shared types and defaults for the parameterised write-back L2 cache.
package l2_cache_pkg;

  localparam int DEF_NUM_SETS = 256;
  localparam int DEF_NUM_WAYS = 8;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 64;

  // Controller states; one request is in flight at a time.
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOOKUP      = 3'd1,
    WB          = 3'd2,
    REFILL_REQ  = 3'd3,
    REFILL_WAIT = 3'd4,
    RESP        = 3'd5
  } state_e;

  // Saturating 32-bit increment for the hit/miss statistics.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/l2_victim_sel.sv
// Replacement choice for one set: lowest-index invalid way, else the
// set's round-robin pointer.
module l2_victim_sel
  import l2_cache_pkg::*;
#(
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [WAY_W-1:0]    rr_ptr,
  output logic [WAY_W-1:0]    way
);

  logic found;

  // Scan upward so the first invalid way found is the lowest index.
  always_comb begin
    way   = rr_ptr;
    found = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!valid[w] && !found) begin
        way   = WAY_W'(w);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_cache_param.sv
// Set-associative write-back / write-allocate cache with one outstanding
// request, a single-beat memory side and saturating hit/miss counters.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The request side is ready only in IDLE. On the memory side,
// mem_req_valid_o and every mem_req_* field are held constant from the
// first valid cycle until the cycle mem_req_ready_i=1 completes it.
// resp_valid_o and mem_resp_valid_i are single-cycle pulses with no
// backpressure; mem_resp_valid_i is only consumed in REFILL_WAIT.
module l2_cache_param
  import l2_cache_pkg::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_write_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              req_ready_o,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_write_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [DATA_W-1:0] mem_req_wdata_o,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_resp_rdata_i,
  output logic [31:0]       hit_count_o,
  output logic [31:0]       miss_count_o
);

  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int TAG_W  = LINE_W - IDX_W;

  // Controller state, kept as a named signal for checkers to bind to.
  state_e state;

  // Registered request (line address only; offset bits are dropped).
  logic [LINE_W-1:0] req_line_q;
  logic              req_write_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [WAY_W-1:0]  victim_q;

  // Per-line metadata (reset) and tag/data storage (not reset).
  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q  [NUM_SETS];
  logic [WAY_W-1:0]    rr_q     [NUM_SETS];
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS][NUM_WAYS];
  logic [DATA_W-1:0]   data_mem [NUM_SETS][NUM_WAYS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim_way;
  logic              victim_dirty;

  logic              arr_we;
  logic [WAY_W-1:0]  arr_way;
  logic [DATA_W-1:0] arr_data;
  logic              arr_dirty;

  assign idx = req_line_q[IDX_W-1:0];
  assign tag = req_line_q[LINE_W-1:IDX_W];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && (tag_mem[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  l2_victim_sel #(
    .NUM_WAYS(NUM_WAYS)
  ) u_victim_sel (
    .valid  (valid_q[idx]),
    .rr_ptr (rr_q[idx]),
    .way    (victim_way)
  );

  assign victim_dirty = valid_q[idx][victim_way] && dirty_q[idx][victim_way];

  // Line install: write hit, write miss without writeback, write after
  // writeback, and clean refill from memory.
  always_comb begin
    arr_we    = 1'b0;
    arr_way   = victim_q;
    arr_data  = req_wdata_q;
    arr_dirty = 1'b1;
    case (state)
      LOOKUP: begin
        if (hit) begin
          if (req_write_q) begin
            arr_we  = 1'b1;
            arr_way = hit_way;
          end
        end else if (req_write_q && !victim_dirty) begin
          arr_we  = 1'b1;
          arr_way = victim_way;
        end
      end
      WB: begin
        if (mem_req_ready_i && req_write_q) arr_we = 1'b1;
      end
      REFILL_WAIT: begin
        if (mem_resp_valid_i) begin
          arr_we    = 1'b1;
          arr_data  = mem_resp_rdata_i;
          arr_dirty = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Tag/data storage write port.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_mem[idx][arr_way]  <= tag;
      data_mem[idx][arr_way] <= arr_data;
    end
  end

  // Controller FSM with registered outputs, metadata and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      req_ready_o     <= 1'b1;
      resp_valid_o    <= 1'b0;
      resp_rdata_o    <= '0;
      mem_req_valid_o <= 1'b0;
      mem_req_write_o <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_req_wdata_o <= '0;
      hit_count_o     <= '0;
      miss_count_o    <= '0;
      req_line_q      <= '0;
      req_write_q     <= 1'b0;
      req_wdata_q     <= '0;
      victim_q        <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            req_line_q  <= req_addr_i[ADDR_W-1:OFF_W];
            req_write_q <= req_write_i;
            req_wdata_q <= req_wdata_i;
            req_ready_o <= 1'b0;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            hit_count_o  <= sat_inc(hit_count_o);
            resp_valid_o <= 1'b1;
            resp_rdata_o <= req_write_q ? '0 : data_mem[idx][hit_way];
            state        <= RESP;
          end else begin
            miss_count_o <= sat_inc(miss_count_o);
            victim_q     <= victim_way;
            rr_q[idx]    <= rr_q[idx] + 1'b1;
            if (victim_dirty) begin
              mem_req_valid_o <= 1'b1;
              mem_req_write_o <= 1'b1;
              mem_req_addr_o  <= {tag_mem[idx][victim_way], idx, {OFF_W{1'b0}}};
              mem_req_wdata_o <= data_mem[idx][victim_way];
              state           <= WB;
            end else if (req_write_q) begin
              resp_valid_o <= 1'b1;
              resp_rdata_o <= '0;
              state        <= RESP;
            end else begin
              mem_req_valid_o <= 1'b1;
              mem_req_write_o <= 1'b0;
              mem_req_addr_o  <= {req_line_q, {OFF_W{1'b0}}};
              mem_req_wdata_o <= '0;
              state           <= REFILL_REQ;
            end
          end
        end
        WB: begin
          if (mem_req_ready_i) begin
            mem_req_write_o <= 1'b0;
            mem_req_wdata_o <= '0;
            if (req_write_q) begin
              mem_req_valid_o <= 1'b0;
              mem_req_addr_o  <= '0;
              resp_valid_o    <= 1'b1;
              resp_rdata_o    <= '0;
              state           <= RESP;
            end else begin
              mem_req_addr_o <= {req_line_q, {OFF_W{1'b0}}};
              state          <= REFILL_REQ;
            end
          end
        end
        REFILL_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
            state           <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (mem_resp_valid_i) begin
            resp_valid_o <= 1'b1;
            resp_rdata_o <= mem_resp_rdata_i;
            state        <= RESP;
          end
        end
        RESP: begin
          resp_valid_o <= 1'b0;
          resp_rdata_o <= '0;
          req_ready_o  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (arr_we) begin
        valid_q[idx][arr_way] <= 1'b1;
        dirty_q[idx][arr_way] <= arr_dirty;
      end
    end
  end

endmodule

// File: doc/l2_cache_param.md
L2_CACHE_PARAM -- requirements
Module: l2_cache_param

Interface
REQ-001 SHALL have parameter NUM_SETS, default 256: number of sets, power of two, >=2.
REQ-002 SHALL have parameter NUM_WAYS, default 8: associativity, power of two, >=2.
REQ-003 SHALL have parameter DATA_W, default 64: line and word width in bits, power of two, >=8.
REQ-004 SHALL have parameter ADDR_W, default 64: byte address width.
REQ-005 SHALL use one clock and an asynchronous active-low reset.
REQ-006 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- req_valid_i  in  1  request valid.
- req_addr_i  in  ADDR_W  byte address; offset bits are ignored.
- req_write_i  in  1  1 = write.
- req_wdata_i  in  DATA_W  write data.
- req_ready_o  out  1  request accepted when valid && ready.
- resp_valid_o  out  1  one-cycle response pulse.
- resp_rdata_o  out  DATA_W  read data; 0 for writes.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts request.
- mem_req_write_o  out  1  1 = writeback.
- mem_req_addr_o  out  ADDR_W  line address, offset bits zero.
- mem_req_wdata_o  out  DATA_W  writeback data.
- mem_resp_valid_i  in  1  refill data valid.
- mem_resp_rdata_i  in  DATA_W  refill data.
- hit_count_o  out  32  read/write hits, saturating.
- miss_count_o  out  32  misses, saturating.

Function
REQ-007 SHALL decode the address as offset = log2(DATA_W/8) LSBs, index = next log2(NUM_SETS) bits, tag = remaining upper bits.
REQ-008 SHALL be write-back and write-allocate, with per-line valid bit, dirty bit and tag.
REQ-009 SHALL implement the FSM states IDLE, LOOKUP, WB, REFILL_REQ, REFILL_WAIT and RESP, and SHALL handle one request at a time.
REQ-010 SHALL assert req_ready_o only in IDLE; an accepted request is registered and the FSM moves to LOOKUP.
REQ-011 On a LOOKUP hit, the cache SHALL update the line (write: data, dirty=1), increment hit_count_o and go to RESP, so resp_valid_o is high exactly 2 cycles after acceptance.
REQ-012 On a LOOKUP miss, the cache SHALL increment miss_count_o and select a victim: the lowest-index invalid way, else the set's round-robin pointer; the pointer SHALL advance by 1 (mod NUM_WAYS) on each replacement in that set.
REQ-013 If the victim is valid and dirty, the FSM SHALL enter WB and drive mem_req_write_o=1 with the victim's address and data.
REQ-014 A write miss SHALL skip refill: it installs req_wdata_i, sets dirty=1 and goes to RESP (after WB if one is needed).
REQ-015 A read miss SHALL enter REFILL_REQ, issue mem_req_write_o=0, then wait in REFILL_WAIT for mem_resp_valid_i, install the data clean, and go to RESP with that data.
REQ-016 mem_req_valid_o and all mem_req_* fields SHALL stay stable until the cycle mem_req_ready_i=1; that cycle completes the transfer.
REQ-017 mem_resp_valid_i SHALL be ignored outside REFILL_WAIT.
REQ-018 RESP SHALL last one cycle and then return to IDLE; responses have no backpressure.
REQ-019 The counters SHALL saturate at 0xFFFF_FFFF.

Reset
REQ-020 While rst_n=0, the block SHALL clear all valid and dirty bits, round-robin pointers, counters and the FSM (state IDLE); req_ready_o=1 and all other outputs SHALL be 0.
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction with no further mem_req_valid_o or resp_valid_o.
REQ-022 Tag and data arrays SHALL need no reset.

Structure
REQ-023 The package l2_cache_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-024 Victim selection SHALL be implemented in sub-module l2_victim_sel, which takes the valid vector and RR pointer and returns the way index.

Verification (NUM_SETS=4, NUM_WAYS=2, DATA_W=64)
REQ-025 Read 0x100 after reset -> mem read addr 0x100; respond 0xDEAD -> resp_rdata_o=0xDEAD; a second read of 0x100 -> hit, resp 2 cycles after accept, no mem traffic, hit=1, miss=1.
REQ-026 Write 0x200=0x1111 (miss) -> no mem request, resp pulse; read 0x200 -> hit, 0x1111.
REQ-027 Write 0x000=0xA, write 0x020=0xB, read 0x040 -> writeback addr 0x000 data 0xA, then refill read addr 0x040.
REQ-028 Hold mem_req_ready_i=0 for 5 cycles during refill -> mem_req_valid_o stays high with a stable address and req_ready_o stays 0.
REQ-029 Assert rst_n=0 in REFILL_WAIT -> outputs reset; pulse mem_resp_valid_i -> ignored; a later read of 0x100 misses.
